// File: rtl/accel_round_sequencer.sv
// Round sequencer for the FIR / matmul / qsort accelerators with per-launch watchdog and checkpoint words.
// Optional WAIT-cycle profiling is enabled by defining CYCLE_PROFILE_EN.
module accel_round_sequencer #(
  parameter int          NUM_ROUNDS  = 3,
  parameter int          TIMEOUT_W   = 20,
  parameter int          TIMEOUT_CYC = 150000,
  parameter int          GAP_CYC     = 8,
  parameter logic [7:0]  CHK_TAG     = 8'hAB
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        go,
  input  logic        abort,
  input  logic        fir_done,
  input  logic        mm_done,
  input  logic        qs_done,
  output logic        fir_start,
  output logic        mm_start,
  output logic        qs_start,
  output logic [15:0] checkbits,
  output logic        busy,
  output logic [3:0]  round_idx,
  output logic        all_done,
  output logic        err,
  output logic [1:0]  err_task,
  output logic [31:0] last_cycles
);

  // state  | meaning
  // IDLE   | waiting for go
  // LAUNCH | one-cycle start pulse for current task
  // WAIT   | waiting for the task's done, watchdog running
  // POST   | holding the end checkpoint for GAP_CYC cycles
  // DONE   | all rounds finished
  // ERR    | watchdog expired; leaves only via abort or reset
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_POST   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TIMEOUT_W-1:0] WD_LAST    = TIMEOUT_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST   = GAP_W'(GAP_CYC - 1);
  localparam logic [3:0]           ROUND_LAST = 4'(NUM_ROUNDS - 1);

  logic [2:0]           state;
  logic [1:0]           task_id;
  logic [3:0]           round;
  logic [TIMEOUT_W-1:0] wd;
  logic [GAP_W-1:0]     gap;
  logic [15:0]          chk;
  logic                 cur_done;
  logic                 launch_ok;

  always_comb begin
    cur_done = 1'b0;
    case (task_id)
      2'd0:    cur_done = fir_done;
      2'd1:    cur_done = mm_done;
      default: cur_done = qs_done;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= S_IDLE;
      task_id <= 2'd0;
      round   <= 4'd0;
      wd      <= '0;
      gap     <= '0;
      chk     <= 16'h0000;
    end else if (abort && state != S_IDLE) begin
      state   <= S_IDLE;
      task_id <= 2'd0;
      round   <= 4'd0;
      chk     <= {CHK_TAG, 8'hEA};
    end else begin
      case (state)
        S_IDLE: begin
          if (go && !abort) begin
            state   <= S_LAUNCH;
            task_id <= 2'd0;
            round   <= 4'd0;
          end
        end
        S_LAUNCH: begin
          chk   <= {CHK_TAG, 2'b00, task_id, 4'h0};
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // done has priority over a watchdog expiring in the same cycle
          if (cur_done) begin
            chk   <= {CHK_TAG, 2'b00, task_id, 4'h1};
            gap   <= '0;
            state <= S_POST;
          end else if (wd == WD_LAST) begin
            chk   <= {CHK_TAG, 2'b00, task_id, 4'hE};
            state <= S_ERR;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_POST: begin
          if (gap == GAP_LAST) begin
            if (task_id != 2'd2) begin
              task_id <= task_id + 2'd1;
              state   <= S_LAUNCH;
            end else if (round != ROUND_LAST) begin
              task_id <= 2'd0;
              round   <= round + 4'd1;
              state   <= S_LAUNCH;
            end else begin
              chk   <= {CHK_TAG, 8'hFF};
              state <= S_DONE;
            end
          end else begin
            gap <= gap + 1'b1;
          end
        end
        S_DONE: begin
          if (go) begin
            state   <= S_LAUNCH;
            task_id <= 2'd0;
            round   <= 4'd0;
          end
        end
        S_ERR: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Start pulses are gated so an abort or reset in the LAUNCH cycle swallows them.
  assign launch_ok = (state == S_LAUNCH) && !abort && !wb_rst_i;
  assign fir_start = launch_ok && (task_id == 2'd0);
  assign mm_start  = launch_ok && (task_id == 2'd1);
  assign qs_start  = launch_ok && (task_id == 2'd2);

  assign checkbits = chk;
  assign busy      = (state == S_LAUNCH) || (state == S_WAIT) || (state == S_POST);
  assign round_idx = round;
  assign all_done  = (state == S_DONE);
  assign err       = (state == S_ERR);
  assign err_task  = (state == S_ERR) ? task_id : 2'd0;

`ifdef CYCLE_PROFILE_EN
  logic [31:0] prof_cnt;
  logic [31:0] prof_last;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      prof_cnt  <= 32'h0;
      prof_last <= 32'h0;
    end else if (state == S_LAUNCH) begin
      prof_cnt <= 32'h0;
    end else if (state == S_WAIT && !abort) begin
      if (prof_cnt != 32'hFFFF_FFFF) prof_cnt <= prof_cnt + 32'h1;
      if (cur_done)
        prof_last <= (prof_cnt == 32'hFFFF_FFFF) ? prof_cnt : prof_cnt + 32'h1;
    end
  end

  assign last_cycles = prof_last;
`else
  assign last_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_accel_round_sequencer.sv
// Randomized bench for accel_round_sequencer: random done latencies and spurious dones, checked against
// checkpoint sequences and timings computed from the sequencing rules.
module tb_accel_round_sequencer;
  localparam int NR  = 3;
  localparam int TO  = 100;
  localparam int GAP = 8;

  logic        clk = 1'b0;
  logic        rst, go, abort, fir_done, mm_done, qs_done;
  logic        fir_start, mm_start, qs_start, busy, all_done, err;
  logic [15:0] checkbits;
  logic [3:0]  round_idx;
  logic [1:0]  err_task;
  logic [31:0] last_cycles;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0, multi_cnt = 0, mm_start_cnt = 0;
  bit mon_en = 0;
  logic [15:0] last_chk;
  logic [15:0] seen_q[$];

  accel_round_sequencer #(.NUM_ROUNDS(NR), .TIMEOUT_W(20), .TIMEOUT_CYC(TO), .GAP_CYC(GAP), .CHK_TAG(8'hAB)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .go(go), .abort(abort),
    .fir_done(fir_done), .mm_done(mm_done), .qs_done(qs_done),
    .fir_start(fir_start), .mm_start(mm_start), .qs_start(qs_start),
    .checkbits(checkbits), .busy(busy), .round_idx(round_idx), .all_done(all_done),
    .err(err), .err_task(err_task), .last_cycles(last_cycles)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    int s;
    s = int'(fir_start) + int'(mm_start) + int'(qs_start);
    start_cnt += s;
    if (s > 1) multi_cnt++;
    if (mm_start) mm_start_cnt++;
    if (mon_en && checkbits !== last_chk) seen_q.push_back(checkbits);
    last_chk = checkbits;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1, "global timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_start(output int which, output int n);
    which = -1;
    n = 0;
    while (which < 0 && n < 300) begin
      tick();
      n++;
      if (fir_start) which = 0;
      else if (mm_start) which = 1;
      else if (qs_start) which = 2;
    end
  endtask

  function automatic logic [31:0] exp_prof(input int lat);
`ifdef CYCLE_PROFILE_EN
    return 32'(lat);
`else
    return 32'h0;
`endif
  endfunction

  // One full go: every launch gets a random latency and a spurious done from another task.
  task automatic run_rounds(input int forced_lat);
    int base, which, n, lat, spur;
    logic [15:0] exp_q[$];
    base = start_cnt;
    seen_q.delete();
    mon_en = 1;
    pulse_go();
    for (int r = 0; r < NR; r++) begin
      for (int t = 0; t < 3; t++) begin
        if (r == 0 && t == 0) begin
          which = fir_start ? 0 : -1;
        end else begin
          wait_start(which, n);
          check_eq("post_gap_len", n, GAP);
        end
        check_eq("start_task", which, t);
        check_eq("round_idx", round_idx, r);
        lat  = (r == 0 && t == 0 && forced_lat > 0) ? forced_lat : $urandom_range(1, TO - 1);
        spur = (lat > 2) ? $urandom_range(1, lat - 1) : 0;
        for (int c = 1; c <= lat; c++) begin
          tick();
          fir_done = 1'b0; mm_done = 1'b0; qs_done = 1'b0;
          if (c == 1) check_eq("chk_launch", checkbits, {8'hAB, 4'(t), 4'h0});
          fir_done = (c == lat && t == 0) || (c == spur && t != 0);
          mm_done  = (c == lat && t == 1) || (c == spur && t != 1);
          qs_done  = (c == lat && t == 2) || (c == spur && t != 2);
        end
        tick();
        fir_done = 1'b0; mm_done = 1'b0; qs_done = 1'b0;
        check_eq("chk_end", checkbits, {8'hAB, 4'(t), 4'h1});
        check_eq("err_after_done", err, 0);
        check_eq("last_cycles", last_cycles, exp_prof(lat));
        exp_q.push_back({8'hAB, 4'(t), 4'h0});
        exp_q.push_back({8'hAB, 4'(t), 4'h1});
      end
    end
    exp_q.push_back(16'hABFF);
    n = 0;
    while (!all_done && n < 50) begin tick(); n++; end
    tick();
    mon_en = 0;
    check_eq("all_done", all_done, 1);
    check_eq("chk_final", checkbits, 16'hABFF);
    check_eq("busy_done", busy, 0);
    check_eq("start_count", start_cnt - base, 3 * NR);
    check_eq("seq_len", seen_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
      check_eq("seq_word", seen_q[i], exp_q[i]);
  endtask

  initial begin
    int which, n, base;
    rst = 1; go = 0; abort = 0; fir_done = 0; mm_done = 0; qs_done = 0;
    repeat (3) tick();
    check_eq("rst_checkbits", checkbits, 16'h0000);
    check_eq("rst_flags", {busy, all_done, err, err_task, fir_start, mm_start, qs_start}, 0);
    check_eq("rst_round", round_idx, 0);
    check_eq("rst_last_cycles", last_cycles, 0);
    rst = 0;
    tick();

    // Full runs; the first launches hit a 37-cycle latency and the exact watchdog limit.
    run_rounds(37);
    run_rounds(TO);

    // done coincident with start and a foreign done are both ignored.
    pulse_go();
    check_eq("fir_start_go", fir_start, 1);
    fir_done = 1'b1;
    tick();
    fir_done = 1'b0;
    repeat (3) tick();
    check_eq("coincident_done_ignored", checkbits, 16'hAB00);
    qs_done = 1'b1;
    tick();
    qs_done = 1'b0;
    tick();
    check_eq("spurious_done_ignored", checkbits, 16'hAB00);
    check_eq("busy_wait", busy, 1);
    fir_done = 1'b1;
    tick();
    fir_done = 1'b0;
    check_eq("fir_late_done", checkbits, 16'hAB01);

    // abort on the mm_start cycle.
    wait_start(which, n);
    check_eq("mm_start_seen", which, 1);
    base = mm_start_cnt;
    abort = 1'b1;
    #1;
    check_eq("mm_start_suppressed", mm_start, 0);
    tick();
    check_eq("abort_mm_count", mm_start_cnt - base, 0);
    check_eq("abort_chk", checkbits, 16'hABEA);
    check_eq("abort_busy", busy, 0);
    abort = 1'b0;
    pulse_go();
    check_eq("restart_fir", fir_start, 1);
    check_eq("restart_round", round_idx, 0);
    tick();
    check_eq("restart_chk", checkbits, 16'hAB00);

    // mm never completes -> watchdog error.
    repeat (4) tick();
    fir_done = 1'b1;
    tick();
    fir_done = 1'b0;
    wait_start(which, n);
    check_eq("mm_start_to", which, 1);
    repeat (TO) tick();
    check_eq("err_before_limit", err, 0);
    tick();
    check_eq("err_set", err, 1);
    check_eq("err_task", err_task, 1);
    check_eq("err_chk", checkbits, 16'hAB1E);
    base = start_cnt;
    pulse_go();
    tick();
    check_eq("err_go_ignored", err, 1);
    check_eq("err_go_no_start", start_cnt - base, 0);
    abort = 1'b1;
    tick();
    check_eq("err_abort_chk", checkbits, 16'hABEA);
    check_eq("err_abort_flags", {err, busy, all_done}, 0);
    base = start_cnt;
    pulse_go();
    tick();
    check_eq("abort_held_go_ignored", {busy, 29'(start_cnt - base)}, 0);
    abort = 1'b0;

    // reset mid-launch drops the pending start pulse.
    base = start_cnt;
    pulse_go();
    rst = 1'b1;
    tick();
    check_eq("rst_start_dropped", start_cnt - base, 0);
    check_eq("rst_mid_chk", checkbits, 16'h0000);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_last", last_cycles, 0);
    rst = 1'b0;
    tick();

    check_eq("one_hot_starts", multi_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/accel_round_sequencer.md
Name: accel_round_sequencer

Overview:
Sequences the three user-project accelerators (FIR, matmul, qsort) through NUM_ROUNDS back-to-back rounds. Each launch is a start/done handshake, and a per-task watchdog guards every launch. The block publishes progress as 16-bit checkpoint words, which top level drives onto mprj_io[31:16]. It sits in the user project area between the Wishbone-side control register and the accelerator start/done pins.

Parameters:
NUM_ROUNDS, 3, number of FIR→matmul→qsort rounds per go (1..15)
TIMEOUT_W, 20, width of watchdog counter
TIMEOUT_CYC, 150000, WAIT-state cycles before a task is declared hung (< 2^TIMEOUT_W)
GAP_CYC, 8, cycles each end-checkpoint is held before the next launch (>=1)
CHK_TAG, 8'hAB, upper byte of every checkpoint word

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  reset; synchronous, active-high
go  in  1  1-cycle pulse; starts a run from IDLE or DONE; ignored otherwise
abort  in  1  level; forces return to IDLE
fir_done, mm_done, qs_done  in  1 each  1-cycle completion pulses from the accelerators
fir_start, mm_start, qs_start  out  1 each  1-cycle launch pulses
checkbits  out  16  checkpoint word
busy  out  1  high in LAUNCH/WAIT/POST
round_idx  out  4  current round, 0-based
all_done  out  1  high in DONE
err  out  1  high in ERR
err_task  out  2  task index that timed out (0 FIR, 1 MM, 2 QS)
last_cycles  out  32  profile count (see Optional Feature)

Behaviour:
- Reset values: all outputs 0, checkbits=16'h0000, state IDLE, task=0, round=0.
- States: IDLE, LAUNCH, WAIT, POST, DONE, ERR.
- IDLE --go--> LAUNCH with task=0, round=0.
- LAUNCH (exactly 1 cycle):
  - Pulse the start of the current task.
  - Register checkbits={CHK_TAG, task[3:0], 4'h0}, giving 0xAB00, 0xAB10 or 0xAB20 on the cycle after entry.
  - Clear the watchdog. Go to WAIT.
- WAIT:
  - Only the done of the current task is honoured. Other dones are ignored. A done coincident with the start pulse is ignored.
  - done → checkbits={CHK_TAG, task, 4'h1}, then go to POST with the gap counter=0.
  - Otherwise increment the watchdog. When the watchdog reaches TIMEOUT_CYC-1 without done → ERR.
  - If done and timeout occur in the same cycle, done wins.
- POST:
  - Hold checkbits for GAP_CYC cycles. Then:
    - task<2: task+1 → LAUNCH.
    - task==2, round<NUM_ROUNDS-1: task=0, round+1 → LAUNCH.
    - task==2, round==NUM_ROUNDS-1: go to DONE.
- DONE: checkbits={CHK_TAG, 8'hFF}, all_done=1. go → LAUNCH with counters zeroed.
- ERR:
  - err=1, err_task=task, checkbits={CHK_TAG, task, 4'hE}.
  - Exits only via abort or reset. go is ignored.
- abort (any state but IDLE) → IDLE next cycle:
  - All start pulses suppressed that cycle.
  - checkbits={CHK_TAG, 8'hEA}; err, all_done and busy clear.
  - abort held high in IDLE: go is ignored.
- Reset mid-run: returns to IDLE; any start pulse pending that cycle is not emitted.
- At most one start output is high in any cycle.
- checkbits changes only on state transitions (registered, glitch-free).

Optional Feature:
Macro CYCLE_PROFILE_EN.
- Defined:
  - A 32-bit counter clears in LAUNCH and increments every WAIT cycle, saturating at 32'hFFFF_FFFF.
  - On done, last_cycles latches the count of WAIT cycles up to and including the done cycle.
  - last_cycles resets to 0 and holds through abort.
- Undefined: last_cycles tied to 32'h0 and no counter is synthesised.

Test Plan:
1. NUM_ROUNDS=3, each accelerator model returns done 20 cycles after its start, go pulse → checkbits sequence AB00,AB01,AB10,AB11,AB20,AB21 ×3, then ABFF. Each Ax01 held ≥8 cycles; all_done=1; exactly 9 start pulses total.
2. TIMEOUT_CYC=100, mm_done never returns → after AB10 + 100 cycles: err=1, err_task=1, checkbits=AB1E. A later go has no effect; abort → ABEA, state IDLE.
3. A spurious qs_done while waiting on FIR, and fir_done coincident with fir_start → both ignored; FIR completes only on a later fir_done.
4. abort asserted on the cycle mm_start would fire → no mm_start pulse, checkbits=ABEA, busy=0. A subsequent go restarts at AB00 with round_idx=0.
5. fir_done on the exact timeout cycle → checkbits=AB01, err stays 0.
6. With CYCLE_PROFILE_EN, fir_done 37 cycles after start → last_cycles=37. Without the macro → last_cycles=0.
